alu_pipe: RTL

- Parametrised, pipelined successor to the single-cycle 32-bit ALU.
- Keeps the same 3-bit function encoding, widened to 8 ops.
- Adds full status flags, a valid/ready handshake with backpressure, a configurable pipeline latency, a pass-through tag, and a saturating completed-operation counter.
- Sits between the issue logic and writeback of the datapath; the combinational datapath lives in a sub-module.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 49 ++++
 rtl/alu_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: function encoding and status-flag bundle shared by the ALU pipeline.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_XOR  = 3'b011,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath; one shared adder serves ADD, SUB and SLT.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          f,
    output logic [WIDTH-1:0] y,
    output alu_flags_t       flags
);

    logic             sub;
    logic             arith;
    logic             ovf;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;

    assign sub   = (f == OP_SUB) || (f == OP_SLT);
    assign arith = sub || (f == OP_ADD);
    assign bb    = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf   = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        y = '0;
        case (f)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = sum[WIDTH-1:0];
            OP_XOR:  y = a ^ b;
            OP_ANDN: y = a & ~b;
            OP_ORN:  y = a | ~b;
            OP_SUB:  y = sum[WIDTH-1:0];
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: y = '0;
        endcase
    end

    assign flags = '{
        zero:     (y == '0),
        negative: y[WIDTH-1],
        carry:    arith & sum[WIDTH],
        overflow: arith & ovf
    };

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready backpressure, tag pass-through and
// a saturating completed-operation counter.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         f,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow,
    output logic [TAG_W-1:0]   out_tag,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] op_count
);

    logic [LATENCY-1:0]             v_q;
    logic [LATENCY-1:0][WIDTH-1:0]  y_q;
    alu_flags_t [LATENCY-1:0]       fl_q;
    logic [LATENCY-1:0][TAG_W-1:0]  tag_q;
    logic [COUNT_W-1:0]             cnt_q;
    logic [COUNT_W-1:0]             cnt_d;
    logic [WIDTH-1:0]               core_y;
    alu_flags_t                     core_fl;
    logic                           advance;
    logic                           in_hs;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .f     (alu_op_e'(f)),
        .y     (core_y),
        .flags (core_fl)
    );

    // Whole pipe moves in lockstep; only a held last stage can stall it.
    assign out_valid = v_q[LATENCY-1];
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign in_hs     = in_valid & advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            y_q   <= '0;
            fl_q  <= '0;
            tag_q <= '0;
        end else if (advance) begin
            v_q[0]   <= in_hs;
            y_q[0]   <= core_y;
            fl_q[0]  <= core_fl;
            tag_q[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i]   <= v_q[i-1];
                y_q[i]   <= y_q[i-1];
                fl_q[i]  <= fl_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign cnt_d = cnt_clr ? '0 : (out_valid && out_ready && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign y        = y_q[LATENCY-1];
    assign zero     = fl_q[LATENCY-1].zero;
    assign negative = fl_q[LATENCY-1].negative;
    assign carry    = fl_q[LATENCY-1].carry;
    assign overflow = fl_q[LATENCY-1].overflow;
    assign out_tag  = tag_q[LATENCY-1];
    assign op_count = cnt_q;

endmodule
